// File: rtl/ad77684_pkg.sv
// ad77684_pkg -- shared types and constants for the AD77684-style serial
// data transmitter.
//   tx_state_e    : transmitter FSM states
//   DEF_*         : default lane count and channel word width
//   HDR_BITS      : header bits at the top of each channel word
//   SAMPLE_BITS   : sample bits below the header
//   gap_reload()  : GAP counter start value giving max(gap,1) idle cycles
package ad77684_pkg;

  localparam int HDR_BITS      = 8;
  localparam int SAMPLE_BITS   = 24;
  localparam int DEF_NUM_LANES = 8;
  localparam int DEF_WORD_BITS = HDR_BITS + SAMPLE_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_e;

  // The GAP counter exits at zero, so a request of 0 still yields one cycle.
  function automatic logic [7:0] gap_reload(input logic [7:0] gap);
    return (gap == 8'd0) ? 8'd0 : gap - 8'd1;
  endfunction

endpackage

// File: rtl/ad77684_lane_ser.sv
// ad77684_lane_ser -- one lane of the parallel-load, MSB-first serializer.
//   clk_i   : DCLK domain clock
//   rst_ni  : asynchronous active-low reset
//   load_i  : capture word_i into the shift register
//   word_i  : channel word for this lane
//   shift_i : present the current MSB on bit_o next cycle and shift left
//   bit_o   : registered serial data; zero on any cycle that is not a shift
module ad77684_lane_ser
  import ad77684_pkg::*;
#(
  parameter int WORD_BITS = DEF_WORD_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [WORD_BITS-1:0] word_i,
  input  logic                 shift_i,
  output logic                 bit_o
);

  logic [WORD_BITS-1:0] sr_q;
  logic                 bit_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      bit_q <= 1'b0;
    end else if (load_i) begin
      sr_q  <= word_i;
      bit_q <= 1'b0;
    end else if (shift_i) begin
      bit_q <= sr_q[WORD_BITS-1];
      sr_q  <= {sr_q[WORD_BITS-2:0], 1'b0};
    end else begin
      bit_q <= 1'b0;
    end
  end

  assign bit_o = bit_q;

endmodule

// File: rtl/ad77684_data_tx.sv
// ad77684_data_tx -- frame transmitter emulating an AD77684 data interface:
// a DRDY pulse followed by WORD_BITS serial bits on every lane, then a
// programmable idle gap. One frame can be buffered while another shifts.
//   clk_in      : clock, also the DCLK domain
//   resetn      : asynchronous active-low reset
//   enable      : permits starting a new frame
//   gap_cycles  : minimum idle cycles after the last bit (0 behaves as 1)
//   frame_data  : NUM_LANES channel words, lane k at [k*WORD_BITS +: WORD_BITS]
//   frame_valid : frame_data offered
//   frame_ready : holding register empty (inverse of hold_full)
//   ready_out   : one-cycle DRDY pulse
//   data_out    : serial data, one bit per lane
//   busy        : frame in SYNC, SHIFT or GAP
//   underrun    : one-cycle pulse when enabled but no frame was ready at GAP end
//
// state | meaning
// IDLE  | nothing in flight, waiting for enable and a buffered frame
// SYNC  | DRDY high, data_out low, first bit staged in the lane serializers
// SHIFT | WORD_BITS cycles of MSB-first data
// GAP   | data_out low for max(gap_cycles,1) cycles
module ad77684_data_tx
  import ad77684_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int WORD_BITS = DEF_WORD_BITS
) (
  input  logic                           clk_in,
  input  logic                           resetn,
  input  logic                           enable,
  input  logic [7:0]                     gap_cycles,
  input  logic [NUM_LANES*WORD_BITS-1:0] frame_data,
  input  logic                           frame_valid,
  output logic                           frame_ready,
  output logic                           ready_out,
  output logic [NUM_LANES-1:0]           data_out,
  output logic                           busy,
  output logic                           underrun
);

  localparam int FRAME_W = NUM_LANES * WORD_BITS;
  localparam int CNT_W   = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tx_state_e          state_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [7:0]         gap_cnt_q;
  logic [FRAME_W-1:0] hold_q;
  logic               hold_full_q;
  logic               ready_q;
  logic               busy_q;
  logic               underrun_q;

  logic slot_open;
  logic start_sync;
  logic accept;
  logic shift_en;

  // A new frame may start from IDLE or on the final GAP cycle.
  assign slot_open  = (state_q == ST_IDLE) || ((state_q == ST_GAP) && (gap_cnt_q == 8'd0));
  assign start_sync = slot_open && enable && hold_full_q;
  // accept and start_sync are exclusive (empty vs. full holding register);
  // a frame offered during SYNC lands in the register just emptied.
  assign accept     = frame_valid && !hold_full_q;
  // Shift in SYNC to stage the MSB, and in SHIFT until the last bit is out.
  assign shift_en   = (state_q == ST_SYNC) || ((state_q == ST_SHIFT) && (bit_cnt_q != '0));

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= 8'd0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      ready_q    <= start_sync;
      underrun_q <= 1'b0;

      if (accept) begin
        hold_q      <= frame_data;
        hold_full_q <= 1'b1;
      end else if (start_sync) begin
        hold_full_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (start_sync) begin
            state_q <= ST_SYNC;
            busy_q  <= 1'b1;
          end
        end
        ST_SYNC: begin
          state_q   <= ST_SHIFT;
          bit_cnt_q <= CNT_LAST;
        end
        ST_SHIFT: begin
          if (bit_cnt_q == '0) begin
            state_q   <= ST_GAP;
            gap_cnt_q <= gap_reload(gap_cycles);
          end else begin
            bit_cnt_q <= bit_cnt_q - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q != 8'd0) begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end else if (start_sync) begin
            state_q <= ST_SYNC;
          end else begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            underrun_q <= enable;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    ad77684_lane_ser #(
      .WORD_BITS(WORD_BITS)
    ) u_ser (
      .clk_i  (clk_in),
      .rst_ni (resetn),
      .load_i (start_sync),
      .word_i (hold_q[k*WORD_BITS +: WORD_BITS]),
      .shift_i(shift_en),
      .bit_o  (data_out[k])
    );
  end

  assign frame_ready = !hold_full_q;
  assign ready_out   = ready_q;
  assign busy        = busy_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_ad77684_data_tx.sv
module tb_ad77684_data_tx;
  localparam int NL = 8;
  localparam int WB = 32;
  localparam int FW = NL * WB;

  logic          clk_in = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic [7:0]    gap_cycles = 8'd0;
  logic [FW-1:0] frame_data = '0;
  logic          frame_valid = 1'b0;
  logic          frame_ready, ready_out, busy, underrun;
  logic [NL-1:0] data_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state: frames accepted but not yet announced by DRDY
  logic [FW-1:0] exp_q[$];
  bit            capturing = 0;
  int            bit_idx = 0;
  logic [FW-1:0] cur_exp = '0;
  logic [FW-1:0] got = '0;
  int drdy_cnt = 0, underrun_cnt = 0;
  int last_drdy = -1, last_space = 0, last_bit_cyc = 0, last_underrun_cyc = 0;
  int gap_at_drdy = 0;

  ad77684_data_tx #(.NUM_LANES(NL), .WORD_BITS(WB)) dut (
    .clk_in     (clk_in),
    .resetn     (resetn),
    .enable     (enable),
    .gap_cycles (gap_cycles),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .busy       (busy),
    .underrun   (underrun)
  );

  always #5 clk_in = ~clk_in;

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  function automatic int gap_eff(input int g);
    return (g < 1) ? 1 : g;
  endfunction

  task automatic check_eq(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < NL; k++) f[k*WB +: WB] = $urandom();
    return f;
  endfunction

  // Monitor: deserialize every DRDY-announced frame and compare with the queue.
  initial forever begin
    @(negedge clk_in);
    if (!resetn) begin
      capturing = 0;
      exp_q.delete();
      last_drdy = -1;
    end else begin
      if (underrun) begin
        underrun_cnt++;
        last_underrun_cyc = cyc;
        check_eq("busy_low_at_underrun", FW'(busy), FW'(0));
      end
      if (ready_out) begin
        drdy_cnt++;
        check_eq("drdy_not_in_shift", FW'(capturing), FW'(0));
        check_eq("dout_zero_in_sync", FW'(data_out), FW'(0));
        if (last_drdy >= 0) begin
          last_space = cyc - last_drdy;
          check_eq("drdy_spacing", FW'(last_space >= 1 + WB + gap_eff(gap_at_drdy)), FW'(1));
        end
        last_drdy   = cyc;
        gap_at_drdy = int'(gap_cycles);
        check_eq("drdy_frame_queued", FW'(exp_q.size() > 0), FW'(1));
        cur_exp   = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        capturing = 1;
        bit_idx   = WB - 1;
        got       = '0;
      end else if (capturing) begin
        check_eq("busy_in_shift", FW'(busy), FW'(1));
        for (int k = 0; k < NL; k++) got[k*WB + bit_idx] = data_out[k];
        if (bit_idx == 0) begin
          check_eq("frame_data", got, cur_exp);
          capturing    = 0;
          last_bit_cyc = cyc;
        end else begin
          bit_idx--;
        end
      end else begin
        check_eq("dout_zero_idle", FW'(data_out), FW'(0));
      end
    end
  end

  task automatic send_frame(input logic [FW-1:0] d, output int waited);
    waited = 0;
    @(negedge clk_in);
    frame_data  = d;
    frame_valid = 1'b1;
    while (!frame_ready && waited < 300) begin
      @(negedge clk_in);
      waited++;
    end
    check_eq("send_accept", FW'(frame_ready), FW'(1));
    if (frame_ready) begin
      @(posedge clk_in);
      exp_q.push_back(d);
    end
    #1 frame_valid = 1'b0;
  endtask

  task automatic wait_drdy(input int target, input int bound);
    int n = 0;
    while (drdy_cnt < target && n < bound) begin
      @(negedge clk_in);
      n++;
    end
    check_eq("wait_drdy", FW'(drdy_cnt >= target), FW'(1));
  endtask

  task automatic wait_shift_bit(input int idx, input int bound);
    int n = 0;
    while (!(capturing && bit_idx <= idx) && n < bound) begin
      @(negedge clk_in);
      n++;
    end
    check_eq("wait_shift", FW'(capturing && bit_idx <= idx), FW'(1));
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (!(!busy && frame_ready && !capturing && exp_q.size() == 0) && n < bound) begin
      @(negedge clk_in);
      n++;
    end
    check_eq("wait_idle", FW'(n < bound), FW'(1));
    @(negedge clk_in);
  endtask

  initial begin
    logic [FW-1:0] f;
    int w, base, u0;

    // reset state
    repeat (3) @(negedge clk_in);
    check_eq("rst_frame_ready", FW'(frame_ready), FW'(1));
    check_eq("rst_ready_out", FW'(ready_out), FW'(0));
    check_eq("rst_data_out", FW'(data_out), FW'(0));
    check_eq("rst_busy", FW'(busy), FW'(0));
    check_eq("rst_underrun", FW'(underrun), FW'(0));
    resetn = 1'b1;

    // header zeros then sample ones on lane 0, back-to-back frames, underrun at end
    gap_cycles = 8'd4;
    enable = 1'b1;
    base = drdy_cnt;
    u0 = underrun_cnt;
    f = '0;
    f[WB-1:0] = 32'h00FF_FFFF;
    send_frame(f, w);
    send_frame(rand_frame(), w);
    wait_drdy(base + 2, 300);
    check_eq("t1_spacing_exact", FW'(last_space), FW'(1 + WB + 4));
    wait_idle(400);
    check_eq("t1_underrun_once", FW'(underrun_cnt - u0), FW'(1));
    check_eq("t1_underrun_at_gap_exit", FW'(last_underrun_cyc - last_bit_cyc), FW'(gap_eff(4) + 1));
    check_eq("t1_busy_low", FW'(busy), FW'(0));

    // gap_cycles=0: frame offered during SHIFT is taken at once, one GAP cycle
    gap_cycles = 8'd0;
    base = drdy_cnt;
    send_frame(rand_frame(), w);
    wait_shift_bit(25, 200);
    send_frame(rand_frame(), w);
    check_eq("t2_accept_immediate", FW'(w), FW'(0));
    @(negedge clk_in);
    check_eq("t2_ready_drops", FW'(frame_ready), FW'(0));
    wait_drdy(base + 2, 300);
    check_eq("t2_spacing_exact", FW'(last_space), FW'(1 + WB + 1));
    check_eq("t2_one_gap_cycle", FW'(last_drdy - last_bit_cyc), FW'(2));
    wait_idle(400);

    // reset mid-SHIFT with another frame buffered
    gap_cycles = 8'd3;
    send_frame(rand_frame(), w);
    wait_shift_bit(28, 200);
    send_frame(rand_frame(), w);
    wait_shift_bit(WB - 1 - 10, 200);
    resetn = 1'b0;
    #1;
    check_eq("t3_rst_data_out", FW'(data_out), FW'(0));
    check_eq("t3_rst_ready_out", FW'(ready_out), FW'(0));
    check_eq("t3_rst_frame_ready", FW'(frame_ready), FW'(1));
    check_eq("t3_rst_busy", FW'(busy), FW'(0));
    repeat (2) @(negedge clk_in);
    resetn = 1'b1;
    base = drdy_cnt;
    repeat (100) @(negedge clk_in);
    check_eq("t3_no_drdy_after_reset", FW'(drdy_cnt), FW'(base));

    // enable dropped mid-SHIFT with the holding register full
    gap_cycles = 8'd2;
    send_frame(rand_frame(), w);
    wait_shift_bit(28, 200);
    send_frame(rand_frame(), w);
    wait_shift_bit(20, 200);
    enable = 1'b0;
    base = drdy_cnt;
    u0 = underrun_cnt;
    wait_shift_bit(0, 200);
    repeat (12) @(negedge clk_in);
    check_eq("t4_no_new_drdy", FW'(drdy_cnt), FW'(base));
    check_eq("t4_no_underrun", FW'(underrun_cnt), FW'(u0));
    check_eq("t4_idle", FW'(busy), FW'(0));
    check_eq("t4_hold_still_full", FW'(frame_ready), FW'(0));
    enable = 1'b1;
    @(negedge clk_in);
    check_eq("t4_sync_next_cycle", FW'(ready_out), FW'(1));
    wait_idle(400);

    // per-channel tagged words, then randomized bursts
    for (int k = 0; k < NL; k++) f[k*WB +: WB] = 32'hA500_0000 | k;
    send_frame(f, w);
    wait_idle(400);
    for (int b = 0; b < 4; b++) begin
      gap_cycles = 8'($urandom_range(0, 6));
      for (int i = 0; i < 6; i++) begin
        repeat ($urandom_range(0, 40)) @(negedge clk_in);
        send_frame(rand_frame(), w);
      end
      wait_idle(2000);
    end
    check_eq("all_frames_sent", FW'(exp_q.size()), FW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ad77684_data_tx.md
AD77684_DATA_TX -- requirements
Module: ad77684_data_tx

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 8, meaning the number of serial data lanes, with one channel per lane.
REQ-002 The block SHALL have parameter WORD_BITS, default 32, meaning the bits per channel word (8 header bits followed by 24 sample bits).
REQ-003 The block SHALL have port clk_in, input, 1 bit: the single clock, which also serves as the DCLK domain.
REQ-004 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: frame transmission is permitted while high.
REQ-006 The block SHALL have port gap_cycles, input, 8 bits: minimum idle cycles between the last data bit and the next DRDY.
REQ-007 The block SHALL have port frame_data, input, NUM_LANES*WORD_BITS bits; lane k uses bits [k*WORD_BITS +: WORD_BITS].
REQ-008 The block SHALL have port frame_valid, input, 1 bit: frame_data is offered.
REQ-009 The block SHALL have port frame_ready, output, 1 bit: the holding register can accept a frame.
REQ-010 The block SHALL have port ready_out, output, 1 bit: DRDY pulse toward the receiver.
REQ-011 The block SHALL have port data_out, output, NUM_LANES bits: serial data with one bit per lane.
REQ-012 The block SHALL have port busy, output, 1 bit: high while a frame is in SYNC, SHIFT or GAP.
REQ-013 The block SHALL have port underrun, output, 1 bit: one-cycle pulse when a frame slot is missed.

Function
REQ-014 A frame SHALL transfer into the holding register on any clk_in edge where frame_valid and frame_ready are both high.
REQ-015 frame_ready SHALL equal NOT hold_full, so a new frame can be buffered while the previous frame shifts.
REQ-016 The state machine SHALL have the states IDLE, SYNC, SHIFT and GAP.
REQ-017 IDLE->SYNC SHALL occur when enable is high and hold_full is high; the holding register moves into the shift registers and hold_full clears in that same cycle.
REQ-018 In SYNC, ready_out SHALL be high for exactly one cycle and data_out SHALL be all zeros.
REQ-019 SHIFT SHALL last exactly WORD_BITS cycles, with lane k driving word bit WORD_BITS-1 down to bit 0, MSB first and one bit per cycle.
REQ-020 The first data bit SHALL appear on the cycle immediately after the ready_out pulse.
REQ-021 After the last bit, the block SHALL enter GAP, with data_out all zeros for max(gap_cycles,1) cycles; gap_cycles SHALL be sampled on entry to GAP.
REQ-022 GAP->SYNC SHALL occur directly when enable and hold_full are both high; otherwise the block SHALL go GAP->IDLE.
REQ-023 If the block leaves GAP for IDLE with enable high and hold_full low, underrun SHALL pulse high for one cycle.
REQ-024 The bit counter SHALL be ceil(log2(WORD_BITS)) bits wide, count down from WORD_BITS-1, and SHALL NOT wrap; the SHIFT exit is decoded at count 0.
REQ-025 A frame load in the same cycle as the SYNC transfer SHALL be accepted; the holding register is then full with the new frame.
REQ-026 Deasserting enable during SYNC, SHIFT or GAP SHALL NOT abort the current frame; it only blocks the next SYNC.
REQ-027 The block SHALL never assert ready_out within 1+WORD_BITS+max(gap_cycles,1) cycles of the previous ready_out.

Reset
REQ-028 On resetn low, the block SHALL immediately force state to IDLE, data_out to 0, ready_out to 0, busy to 0, underrun to 0 and hold_full to 0, giving frame_ready 1.
REQ-029 Reset mid-frame SHALL discard both the shifting frame and the buffered frame; no partial bits SHALL appear after resetn rises.
REQ-030 All outputs SHALL be registered, except frame_ready, which is a direct inversion of the hold_full register.

Structure
REQ-031 Package ad77684_pkg SHALL hold the state enum (IDLE/SYNC/SHIFT/GAP), the NUM_LANES and WORD_BITS defaults, and the header field widths (8 header, 24 sample).
REQ-032 The per-lane parallel-load MSB-first shifter SHALL be sub-module ad77684_lane_ser, instantiated NUM_LANES times via generate.

Verification
REQ-033 Load lane0=32'h00FFFFFF and other lanes 0, gap_cycles=4, enable=1 -> ready_out one cycle; lane0 carries 8 zeros then 24 ones; other lanes stay 0; the DRDY-to-DRDY spacing is at least 37 cycles.
REQ-034 With each lane word k = 32'hA5000000|k, loopback into the ad77684_if receiver -> receiver adc_data matches the words for all 8 channels.
REQ-035 Offer a second frame during SHIFT with gap_cycles=0 -> it is accepted immediately, frame_ready drops, and the next DRDY occurs exactly 1 GAP cycle after the last bit.
REQ-036 Provide no second frame with enable=1 -> underrun pulses once at GAP exit, the block goes to IDLE, and busy falls.
REQ-037 Assert resetn low at bit 10 of SHIFT -> data_out=0, ready_out=0 and frame_ready=1 immediately; after release there is no DRDY until a new frame is loaded.
REQ-038 Drop enable mid-SHIFT with the holding register full -> the current frame completes, the block goes to IDLE with no underrun, and re-enabling starts SYNC on the next cycle.
